// File: rtl/koopa_anim_pkg.sv
// Shared types and constants for the koopa animation sequencer:
// sprite geometry, animation enum, and per-frame ROM base offsets.
package koopa_anim_pkg;

  localparam int SPR_W        = 30;
  localparam int SPR_H        = 46;
  localparam int FRAMES       = 4;
  localparam int ADDR_W       = 13;
  localparam int TICKS_PER_FR = 8;
  localparam int LAND_TICKS   = 6;
  localparam int SPR_PIX      = SPR_W * SPR_H;

  localparam int TICK_W = $clog2(TICKS_PER_FR);
  localparam int LAND_W = $clog2(LAND_TICKS);
  localparam int COL_W  = $clog2(SPR_W);
  localparam int DY_W   = $clog2(SPR_H);
  localparam int FIDX_W = $clog2(FRAMES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2,
    LAND = 2'd3
  } anim_e;

  typedef logic [ADDR_W-1:0] addr_t;

  // Frames sit back to back in each ROM, so frame k starts at k*SPR_PIX.
  localparam addr_t FRAME_BASE [FRAMES] = '{
    addr_t'(0 * SPR_PIX),
    addr_t'(1 * SPR_PIX),
    addr_t'(2 * SPR_PIX),
    addr_t'(3 * SPR_PIX)
  };

  function automatic logic [FIDX_W-1:0] next_frame(input logic [FIDX_W-1:0] cur,
                                                   input logic              hold_last);
    if (hold_last && (cur == FIDX_W'(FRAMES - 1))) begin
      return cur;
    end else begin
      return cur + FIDX_W'(1);
    end
  endfunction

endpackage

// File: rtl/koopa_anim_sequencer_if.sv
// Bundle between player physics / video timing (master) and the sequencer (slave).
interface koopa_anim_sequencer_if;

  logic                        frame_tick;
  logic                        grounded;
  logic                        walk_req;
  logic                        jump_req;
  logic                        facing_left;
  logic [9:0]                  hcount;
  logic [9:0]                  vcount;
  logic [9:0]                  sprite_x;
  logic [9:0]                  sprite_y;
  logic [1:0]                  anim_sel;
  koopa_anim_pkg::addr_t       rom_addr;
  logic                        pix_valid;
  logic [1:0]                  frame_idx;

  modport master (
    output frame_tick, grounded, walk_req, jump_req, facing_left,
    output hcount, vcount, sprite_x, sprite_y,
    input  anim_sel, rom_addr, pix_valid, frame_idx
  );

  modport slave (
    input  frame_tick, grounded, walk_req, jump_req, facing_left,
    input  hcount, vcount, sprite_x, sprite_y,
    output anim_sel, rom_addr, pix_valid, frame_idx
  );

endinterface

// File: rtl/koopa_sprite_addr_gen.sv
// Two-stage beam-to-ROM-address pipeline with horizontal mirroring.
// Stage 2 also captures anim/frame so each pixel carries one consistent pair.
module koopa_sprite_addr_gen
  import koopa_anim_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hcount_i,
  input  logic [9:0]        vcount_i,
  input  logic [9:0]        sprite_x_i,
  input  logic [9:0]        sprite_y_i,
  input  logic              facing_i,
  input  anim_e             anim_i,
  input  logic [FIDX_W-1:0] frame_idx_i,
  output addr_t             rom_addr_o,
  output logic              pix_valid_o,
  output anim_e             anim_sel_o,
  output logic [FIDX_W-1:0] frame_idx_o
);

  logic [10:0]       dx_s;
  logic [10:0]       dy_s;
  logic              in_box_s;
  logic [COL_W-1:0]  col_s;

  logic              in_q;
  logic [DY_W-1:0]   dy_q;
  logic [COL_W-1:0]  col_q;

  addr_t             rom_addr_d;
  addr_t             rom_addr_q;
  logic              pix_valid_q;
  anim_e             anim_q;
  logic [FIDX_W-1:0] frame_idx_q;

  // Left-of/above-origin beams wrap to large values and fall out of the box.
  always_comb begin
    dx_s     = {1'b0, hcount_i} - {1'b0, sprite_x_i};
    dy_s     = {1'b0, vcount_i} - {1'b0, sprite_y_i};
    in_box_s = (dx_s < 11'(SPR_W)) && (dy_s < 11'(SPR_H));
    if (facing_i) begin
      col_s = COL_W'(SPR_W - 1) - dx_s[COL_W-1:0];
    end else begin
      col_s = dx_s[COL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q  <= 1'b0;
      dy_q  <= '0;
      col_q <= '0;
    end else begin
      in_q  <= in_box_s;
      dy_q  <= in_box_s ? dy_s[DY_W-1:0] : '0;
      col_q <= in_box_s ? col_s : '0;
    end
  end

  always_comb begin
    if (in_q) begin
      rom_addr_d = FRAME_BASE[frame_idx_i] + addr_t'(dy_q) * addr_t'(SPR_W) + addr_t'(col_q);
    end else begin
      rom_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q  <= '0;
      pix_valid_q <= 1'b0;
      anim_q      <= IDLE;
      frame_idx_q <= '0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      pix_valid_q <= in_q;
      anim_q      <= anim_i;
      frame_idx_q <= frame_idx_i;
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign pix_valid_o = pix_valid_q;
  assign anim_sel_o  = anim_q;
  assign frame_idx_o = frame_idx_q;

endmodule

// File: rtl/koopa_anim_sequencer.sv
// Koopa animation sequencer: picks animation and frame on each video frame tick
// and drives the ROM select/address for the current beam position.
module koopa_anim_sequencer
  import koopa_anim_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  koopa_anim_sequencer_if.slave  bus
);

  anim_e             state_q;
  anim_e             state_d;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [LAND_W-1:0] land_cnt_q;
  logic [FIDX_W-1:0] frame_idx_q;
  logic              facing_q;

  addr_t             rom_addr_s;
  logic              pix_valid_s;
  anim_e             anim_sel_s;
  logic [FIDX_W-1:0] frame_idx_s;

  // Transition rules; jump always wins over walk.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, WALK: begin
        if (bus.jump_req && bus.grounded) begin
          state_d = JUMP;
        end else if (!bus.grounded) begin
          state_d = JUMP;
        end else if (bus.walk_req) begin
          state_d = WALK;
        end else begin
          state_d = IDLE;
        end
      end
      JUMP: begin
        if (bus.grounded) begin
          state_d = LAND;
        end else begin
          state_d = JUMP;
        end
      end
      LAND: begin
        if (bus.jump_req && bus.grounded) begin
          state_d = JUMP;
        end else if (land_cnt_q == '0) begin
          state_d = bus.walk_req ? WALK : IDLE;
        end else begin
          state_d = LAND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Everything moves only on frame_tick so a frame is never torn mid-scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      land_cnt_q  <= '0;
      frame_idx_q <= '0;
      facing_q    <= 1'b0;
    end else if (bus.frame_tick) begin
      state_q  <= state_d;
      facing_q <= bus.facing_left;

      if ((state_q == JUMP) && (state_d == LAND)) begin
        land_cnt_q <= LAND_W'(LAND_TICKS - 1);
      end else if ((state_q == LAND) && (state_d == LAND)) begin
        land_cnt_q <= land_cnt_q - LAND_W'(1);
      end else begin
        land_cnt_q <= land_cnt_q;
      end

      if (state_d != state_q) begin
        tick_cnt_q  <= '0;
        frame_idx_q <= '0;
      end else if (tick_cnt_q == TICK_W'(TICKS_PER_FR - 1)) begin
        tick_cnt_q  <= '0;
        frame_idx_q <= next_frame(frame_idx_q, state_q == JUMP);
      end else begin
        tick_cnt_q  <= tick_cnt_q + TICK_W'(1);
      end
    end
  end

  koopa_sprite_addr_gen u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .hcount_i    (bus.hcount),
    .vcount_i    (bus.vcount),
    .sprite_x_i  (bus.sprite_x),
    .sprite_y_i  (bus.sprite_y),
    .facing_i    (facing_q),
    .anim_i      (state_q),
    .frame_idx_i (frame_idx_q),
    .rom_addr_o  (rom_addr_s),
    .pix_valid_o (pix_valid_s),
    .anim_sel_o  (anim_sel_s),
    .frame_idx_o (frame_idx_s)
  );

  assign bus.rom_addr  = rom_addr_s;
  assign bus.pix_valid = pix_valid_s;
  assign bus.anim_sel  = anim_sel_s;
  assign bus.frame_idx = frame_idx_s;

endmodule

// File: tb/tb_koopa_anim_sequencer.sv
// Self-checking bench for koopa_anim_sequencer: directed table, corner sequences,
// and randomized ticks/beam positions against a behavioural model.
module tb_koopa_anim_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  koopa_anim_sequencer_if bus ();

  koopa_anim_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: animation 0..3, frame, ticks since last step, landing ticks left, facing.
  int m_anim, m_frame, m_tick, m_land, m_facing;

  typedef struct {
    string nm;
    int    facing;
    int    sx, sy, h, v;
    int    exp_valid;
    int    exp_addr;
  } pix_vec_t;

  pix_vec_t tbl [10];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic int in_box(input int sx, sy, h, v);
    int dx = h - sx;
    int dy = v - sy;
    return (dx >= 0 && dx < 30 && dy >= 0 && dy < 46) ? 1 : 0;
  endfunction

  function automatic int pix_addr(input int sx, sy, h, v, facing, frame);
    int dx = h - sx;
    int dy = v - sy;
    if (in_box(sx, sy, h, v) == 0) return 0;
    return frame * 1380 + dy * 30 + (facing != 0 ? 29 - dx : dx);
  endfunction

  task automatic model_reset();
    m_anim = 0; m_frame = 0; m_tick = 0; m_land = 0; m_facing = 0;
  endtask

  task automatic model_tick(input int g, w, j, f);
    int nxt;
    case (m_anim)
      0, 1:    nxt = (!g || j) ? 2 : (w ? 1 : 0);
      2:       nxt = g ? 3 : 2;
      default: begin
        if (j && g) nxt = 2;
        else if (m_land == 0) nxt = w ? 1 : 0;
        else begin nxt = 3; m_land = m_land - 1; end
      end
    endcase
    if (m_anim == 2 && nxt == 3) m_land = 5;
    if (nxt != m_anim) begin
      m_frame = 0;
      m_tick  = 0;
    end else begin
      m_tick = m_tick + 1;
      if (m_tick == 8) begin
        m_tick  = 0;
        m_frame = (m_anim == 2) ? ((m_frame < 3) ? m_frame + 1 : 3) : (m_frame + 1) % 4;
      end
    end
    m_anim   = nxt;
    m_facing = f;
  endtask

  task automatic set_beam(input int sx, sy, h, v);
    bus.sprite_x = 10'(sx);
    bus.sprite_y = 10'(sy);
    bus.hcount   = 10'(h);
    bus.vcount   = 10'(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic tick(input logic g, w, j, f);
    bus.grounded    = g;
    bus.walk_req    = w;
    bus.jump_req    = j;
    bus.facing_left = f;
    bus.frame_tick  = 1'b1;
    model_tick(int'(g), int'(w), int'(j), int'(f));
    @(posedge clk); #1;
    bus.frame_tick  = 1'b0;
  endtask

  task automatic ticks(input int n, input logic g, w, j, f);
    for (int k = 0; k < n; k++) tick(g, w, j, f);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{"org",       0, 100, 50, 100, 50, 1, 0};
    tbl[1] = '{"far_corner",0, 100, 50, 129, 95, 1, 1379};
    tbl[2] = '{"mirror_org",1, 100, 50, 100, 50, 1, 29};
    tbl[3] = '{"left_out",  0, 100, 50,  99, 50, 0, 0};
    tbl[4] = '{"right_out", 0, 100, 50, 130, 50, 0, 0};
    tbl[5] = '{"wrap_x",    0, 1000, 50,  5, 50, 0, 0};
    tbl[6] = '{"mirror_end",1, 100, 50, 129, 50, 1, 0};
    tbl[7] = '{"below_out", 0, 100, 50, 100, 96, 0, 0};
    tbl[8] = '{"above_out", 0, 100, 50, 100, 49, 0, 0};
    tbl[9] = '{"mirror_mid",1, 100, 50, 110, 60, 1, 319};

    rst = 1'b1;
    bus.frame_tick = 1'b0; bus.grounded = 1'b1; bus.walk_req = 1'b0;
    bus.jump_req = 1'b0; bus.facing_left = 1'b0;
    set_beam(100, 50, 600, 400);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_anim", 16'(bus.anim_sel), 16'd0);
    chk("rst_frame", 16'(bus.frame_idx), 16'd0);
    chk("rst_valid", 16'(bus.pix_valid), 16'd0);
    chk("rst_addr", 16'(bus.rom_addr), 16'd0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      tick(1'b1, 1'b0, 1'b0, tbl[i].facing[0]);
      set_beam(tbl[i].sx, tbl[i].sy, tbl[i].h, tbl[i].v);
      settle();
      chk({tbl[i].nm, "_valid"}, 16'(bus.pix_valid), 16'(tbl[i].exp_valid));
      chk({tbl[i].nm, "_addr"}, 16'(bus.rom_addr), 16'(tbl[i].exp_addr));
    end

    // Idle animates too: 8 ticks reach frame 1, mirrored second row.
    do_reset();
    set_beam(100, 50, 600, 400);
    ticks(8, 1'b1, 1'b0, 1'b0, 1'b1);
    set_beam(100, 50, 100, 51);
    settle();
    chk("f1_frame", 16'(bus.frame_idx), 16'd1);
    chk("f1_addr", 16'(bus.rom_addr), 16'd1439);

    // Walk: enter, step every 8 ticks, wrap 3->0, then reset mid-animation.
    do_reset();
    set_beam(100, 50, 600, 400);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("walk_anim", 16'(bus.anim_sel), 16'd1);
    chk("walk_f0", 16'(bus.frame_idx), 16'd0);
    ticks(7, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("walk_f0_hold", 16'(bus.frame_idx), 16'd0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("walk_f1", 16'(bus.frame_idx), 16'd1);
    ticks(16, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("walk_f3", 16'(bus.frame_idx), 16'd3);
    ticks(8, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("walk_wrap", 16'(bus.frame_idx), 16'd0);
    ticks(16, 1'b1, 1'b1, 1'b0, 1'b0);
    set_beam(100, 50, 100, 50);
    settle();
    chk("walk_f2", 16'(bus.frame_idx), 16'd2);
    chk("walk_f2_valid", 16'(bus.pix_valid), 16'd1);
    chk("walk_f2_addr", 16'(bus.rom_addr), 16'd2760);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("mid_rst_anim", 16'(bus.anim_sel), 16'd0);
    chk("mid_rst_frame", 16'(bus.frame_idx), 16'd0);
    chk("mid_rst_valid", 16'(bus.pix_valid), 16'd0);
    chk("mid_rst_addr", 16'(bus.rom_addr), 16'd0);

    // Jump beats walk, holds last frame airborne, lands for 6 ticks.
    do_reset();
    set_beam(100, 50, 600, 400);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    chk("jump_anim", 16'(bus.anim_sel), 16'd2);
    ticks(40, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("jump_air_anim", 16'(bus.anim_sel), 16'd2);
    chk("jump_hold_f3", 16'(bus.frame_idx), 16'd3);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("land_anim", 16'(bus.anim_sel), 16'd3);
    chk("land_f0", 16'(bus.frame_idx), 16'd0);
    ticks(5, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("land_still", 16'(bus.anim_sel), 16'd3);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("land_to_idle", 16'(bus.anim_sel), 16'd0);

    do_reset();
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("land2_still", 16'(bus.anim_sel), 16'd3);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("land_to_walk", 16'(bus.anim_sel), 16'd1);

    // Randomized ticks and beam positions against the model.
    do_reset();
    for (int it = 0; it < 300; it++) begin
      int g, w, j, f, extra, sx, sy, h, v;
      g = (($urandom % 4) != 0) ? 1 : 0;
      w = int'($urandom % 2);
      j = (($urandom % 5) == 0) ? 1 : 0;
      f = int'($urandom % 2);
      extra = int'($urandom_range(0, 3));
      for (int k = 0; k <= extra; k++) tick(g[0], w[0], j[0], f[0]);
      sx = int'($urandom_range(0, 1023));
      sy = int'($urandom_range(0, 1023));
      if (($urandom % 8) == 0) begin
        h = int'($urandom_range(0, 1023));
        v = int'($urandom_range(0, 1023));
      end else begin
        h = (sx + int'($urandom_range(0, 36)) - 3) & 1023;
        v = (sy + int'($urandom_range(0, 52)) - 3) & 1023;
      end
      set_beam(sx, sy, h, v);
      settle();
      chk("rnd_anim", 16'(bus.anim_sel), 16'(m_anim));
      chk("rnd_frame", 16'(bus.frame_idx), 16'(m_frame));
      chk("rnd_valid", 16'(bus.pix_valid), 16'(in_box(sx, sy, h, v)));
      chk("rnd_addr", 16'(bus.rom_addr), 16'(pix_addr(sx, sy, h, v, m_facing, m_frame)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
